// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_mem_pkg: funct3 codes, LSU state encoding, access-size helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Stores only know sb/sh/sw; every other code falls back to a word access.
  function automatic logic [1:0] access_size(input logic [2:0] funct3, input logic is_store);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (funct3 == LB || (!is_store && funct3 == LBU)) sz = SZ_BYTE;
    if (funct3 == LH || (!is_store && funct3 == LHU)) sz = SZ_HALF;
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_extend: lane select and sign/zero extension of a loaded word
// Rev 1.0
// ---------------------------------------------------------------------------
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      result_o = {{16{half_sel[15]}}, half_sel};
      LBU:     result_o = {24'h000000, byte_sel};
      LHU:     result_o = {16'h0000, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_lsu: MEM-stage load/store unit with handshaked data-memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage_lsu
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             we_q;
  logic [29:0]      word_addr_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [2:0]       funct3_q;
  logic [31:0]      rdata_q;
  logic             bus_err_q;

  logic        access;
  logic [1:0]  size;
  logic        misaligned;
  logic        issue;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] load_ext;

  assign access     = MemReadM | MemWriteM;
  assign size       = access_size(funct3M, MemWriteM);
  assign misaligned = is_misaligned(size, ALUResultM[1:0]);
  assign issue      = access & ~misaligned;

  // Reads carry no lanes; write wins when both strobes are set.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (MemWriteM) begin
      case (size)
        SZ_BYTE: begin
          wstrb_d = 4'b0001 << ALUResultM[1:0];
          wdata_d = {4{WriteDataM[7:0]}};
        end
        SZ_HALF: begin
          wstrb_d = ALUResultM[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{WriteDataM[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = WriteDataM;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .result_o  (load_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      word_addr_q <= '0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            req_q       <= 1'b1;
            we_q        <= MemWriteM;
            word_addr_q <= ALUResultM[31:2];
            addr_lo_q   <= ALUResultM[1:0];
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            funct3_q    <= funct3M;
            cnt_q       <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // A response on the last allowed cycle still beats the timeout.
          if (dmem_ready) begin
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= load_ext;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            rdata_q   <= '0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = {word_addr_q, 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign ReadDataM  = rdata_q;
  assign BusErrM    = bus_err_q;
  assign StallM     = reset & (((state_q == IDLE) & issue) | (state_q == WAIT));
  assign MisalignM  = reset & (state_q == IDLE) & access & misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu: directed scoreboard bench for mem_stage_lsu (TIMEOUT=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        reqq[$];
  logic [31:0] rdq[$];
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access: issue in IDLE, answer after lat WAIT cycles, check in DONE.
  task automatic do_access(input string tag, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                           input int lat, input logic [31:0] exp_rd);
    req_t exp_req;
    req_t got;
    int   stall_cycles;
    stall_cycles = 0;
    MemWriteM  = wr;
    MemReadM   = ~wr;
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    reqq.push_back('{we: wr, addr: {a[31:2], 2'b00}, wdata: exp_wdata, wstrb: exp_wstrb});
    if (!wr) rdq.push_back(exp_rd);
    #1;
    chk({tag, "_issue_stall"}, StallM, 1'b1);
    chk({tag, "_issue_mis"}, MisalignM, 1'b0);
    if (StallM) stall_cycles++;
    tick();
    chk({tag, "_req"}, dmem_req, 1'b1);
    if (reqq.size() != 0) begin
      exp_req = reqq.pop_front();
      got     = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};
      chk({tag, "_we"}, got.we, exp_req.we);
      chk({tag, "_addr"}, got.addr, exp_req.addr);
      chk({tag, "_wstrb"}, got.wstrb, exp_req.wstrb);
      if (wr) chk({tag, "_wdata"}, got.wdata, exp_req.wdata);
    end
    for (int i = 0; i < lat; i++) begin
      if (StallM) stall_cycles++;
      tick();
      chk({tag, "_addr_hold"}, dmem_addr, {a[31:2], 2'b00});
    end
    if (StallM) stall_cycles++;
    dmem_ready = 1'b1;
    dmem_rdata = mem[dmem_addr[5:2]];
    if (dmem_we) begin
      for (int b = 0; b < 4; b++)
        if (dmem_wstrb[b]) mem[dmem_addr[5:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
    end
    tick();
    dmem_ready = 1'b0;
    chk({tag, "_done_stall"}, StallM, 1'b0);
    chk({tag, "_done_req"}, dmem_req, 1'b0);
    chk({tag, "_stall_cycles"}, stall_cycles, lat + 2);
    if (!wr && rdq.size() != 0) chk({tag, "_rdata"}, ReadDataM, rdq.pop_front());
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    reset      = 1'b0;
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    funct3M    = LW;
    ALUResultM = 32'h11;
    WriteDataM = 32'h0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;

    // Reset with a misaligned load pending: no flags, all outputs zero.
    tick();
    tick();
    chk("rst_stall", StallM, 1'b0);
    chk("rst_mis", MisalignM, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wstrb", dmem_wstrb, 4'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_buserr", BusErrM, 1'b0);
    MemReadM = 1'b0;
    reset    = 1'b1;
    tick();
    chk("idle_stall", StallM, 1'b0);

    do_access("sw10",   1'b1, SW,  32'h10, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'b1111, 0, 32'h0);
    do_access("sb13",   1'b1, SB,  32'h13, 32'h000000C3, 32'hC3C3C3C3, 4'b1000, 1, 32'h0);
    do_access("lb13",   1'b0, LB,  32'h13, 32'h0, 32'h0, 4'b0000, 0, 32'hFFFFFFC3);
    do_access("lbu13",  1'b0, LBU, 32'h13, 32'h0, 32'h0, 4'b0000, 2, 32'h000000C3);
    do_access("sw10b",  1'b1, SW,  32'h10, 32'h80017FFF, 32'h80017FFF, 4'b1111, 0, 32'h0);
    do_access("lh12",   1'b0, LH,  32'h12, 32'h0, 32'h0, 4'b0000, 0, 32'hFFFF8001);
    do_access("lhu12",  1'b0, LHU, 32'h12, 32'h0, 32'h0, 4'b0000, 1, 32'h00008001);
    do_access("lh10",   1'b0, LH,  32'h10, 32'h0, 32'h0, 4'b0000, 0, 32'h00007FFF);
    do_access("lb11",   1'b0, LB,  32'h11, 32'h0, 32'h0, 4'b0000, 0, 32'h0000007F);
    do_access("sh16",   1'b1, SH,  32'h16, 32'h1234BEEF, 32'hBEEFBEEF, 4'b1100, 3, 32'h0);
    do_access("lw14",   1'b0, LW,  32'h14, 32'h0, 32'h0, 4'b0000, 0, 32'hBEEF0000);
    do_access("f3_011", 1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 4'b0000, 0, 32'hBEEF0000);

    // Misaligned lw and sh: flag only, nothing reaches the bus.
    MemReadM   = 1'b1;
    funct3M    = LW;
    ALUResultM = 32'h11;
    #1;
    chk("mis_lw_flag", MisalignM, 1'b1);
    chk("mis_lw_stall", StallM, 1'b0);
    tick();
    chk("mis_lw_noreq", dmem_req, 1'b0);
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    funct3M    = SH;
    ALUResultM = 32'h13;
    WriteDataM = 32'hFFFFFFFF;
    #1;
    chk("mis_sh_flag", MisalignM, 1'b1);
    chk("mis_sh_stall", StallM, 1'b0);
    tick();
    chk("mis_sh_noreq", dmem_req, 1'b0);
    MemWriteM = 1'b0;
    #1;
    chk("mis_clear", MisalignM, 1'b0);
    tick();
    do_access("lw10_chk", 1'b0, LW, 32'h10, 32'h0, 32'h0, 4'b0000, 0, 32'h80017FFF);

    // Timeout: no ready ever.
    MemReadM   = 1'b1;
    funct3M    = LW;
    ALUResultM = 32'h10;
    tick();
    n = 0;
    while (dmem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 4);
    chk("to_buserr", BusErrM, 1'b1);
    chk("to_rdata", ReadDataM, 32'h0);
    chk("to_stall", StallM, 1'b0);
    MemReadM = 1'b0;
    tick();
    chk("to_buserr_pulse", BusErrM, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ready = 1'b0;
    chk("to_late_ready", ReadDataM, 32'h0);
    chk("to_late_req", dmem_req, 1'b0);

    // Reset in the second WAIT cycle abandons the request.
    do_access("lbu13b", 1'b0, LBU, 32'h13, 32'h0, 32'h0, 4'b0000, 0, 32'h00000080);
    MemReadM   = 1'b1;
    funct3M    = LW;
    ALUResultM = 32'h10;
    tick();
    tick();
    chk("rw_req_wait2", dmem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("rw_stall", StallM, 1'b0);
    chk("rw_mis", MisalignM, 1'b0);
    tick();
    chk("rw_req", dmem_req, 1'b0);
    chk("rw_addr", dmem_addr, 32'h0);
    chk("rw_wstrb", dmem_wstrb, 4'h0);
    chk("rw_rdata", ReadDataM, 32'h0);
    chk("rw_buserr", BusErrM, 1'b0);
    reset      = 1'b1;
    MemReadM   = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h12345678;
    tick();
    dmem_ready = 1'b0;
    chk("rw_ready_ignored", ReadDataM, 32'h0);
    chk("rw_stall_after", StallM, 1'b0);
    chk("rw_req_after", dmem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
